// File: rtl/raster_to_ndc_pkg.sv
// Shared types and constants for the raster -> NDC conversion block.
package raster_to_ndc_pkg;

    typedef logic [15:0]        f16;
    typedef logic signed [15:0] i16;

    typedef struct packed {
        f16 y;
        f16 x;
    } vec2_f16;

    typedef struct packed {
        i16 y;
        i16 x;
    } vec2_i16;

    // Unsigned fraction, value = raw / 2^16
    typedef logic [15:0] uq0_16;

    localparam f16          F16_ONE       = 16'h3C00;
    localparam f16          F16_MAX       = 16'h7BFF;
    localparam int unsigned NDC_FRAC_BITS = 17;

endpackage

// File: rtl/raster_to_ndc_fixed_to_f16.sv
// Combinational signed Q.17 (36b) to f16 conversion, round-to-nearest-even.
// Results below 2^-14 flush to signed zero; results too large for f16 saturate to +/-max.
module raster_to_ndc_fixed_to_f16
    import raster_to_ndc_pkg::*;
(
    input  logic signed [35:0] val_i,
    output f16                 f16_o
);

    logic        sign;
    logic [35:0] mag;
    logic [5:0]  lead;
    logic [35:0] norm;
    logic        round_up;
    logic [10:0] mant_sum;
    logic        carry;
    logic [6:0]  exp_b;

    // Sign-magnitude split, normalise, round, then classify zero/flush/saturate/normal
    always_comb begin
        sign = val_i[35];
        mag  = sign ? -val_i : val_i;
        lead = '0;
        for (int i = 0; i < 36; i++) begin
            if (mag[i]) begin
                lead = 6'(i);
            end
        end
        // Leading one lands on bit 35; bit 35 doubles as the non-zero flag
        norm     = mag << (6'd35 - lead);
        round_up = norm[24] & ((|norm[23:0]) | norm[25]);
        mant_sum = {1'b0, norm[34:25]} + {10'b0, round_up};
        carry    = mant_sum[10];
        // Unbiased exponent is lead-17, bias 15
        exp_b    = {1'b0, lead} - 7'd2 + {6'b0, carry};

        if (!norm[35]) begin
            f16_o = 16'h0000;
        end else if (lead < 6'd3) begin
            f16_o = {sign, 15'b0};
        end else if (exp_b > 7'd30) begin
            f16_o = {sign, F16_MAX[14:0]};
        end else begin
            f16_o = {sign, exp_b[4:0], mant_sum[9:0]};
        end
    end

endmodule

// File: rtl/raster_to_ndc.sv
// Signed pixel coords -> f16 NDC: ndc_x = (x+c)/W, ndc_y = 1-(y+c)/H.
// Four-stage valid/ready pipeline with a global enable; the source pixel travels with the result.
module raster_to_ndc
    import raster_to_ndc_pkg::*;
#(
    parameter bit CENTER = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    cfg_load,
    input  uq0_16   cfg_inv_w,
    input  uq0_16   cfg_inv_h,
    input  logic    pix_valid,
    output logic    pix_ready,
    input  vec2_i16 pix,
    output logic    ndc_valid,
    input  logic    ndc_ready,
    output vec2_f16 ndc_pt,
    output vec2_i16 ndc_pix
);

    localparam logic signed [35:0] OneQ = 36'(1) << NDC_FRAC_BITS;

    logic en;

    uq0_16 inv_w_q, inv_w_d, inv_h_q, inv_h_d;

    logic               s1_valid_q, s1_valid_d;
    vec2_i16            s1_pix_q, s1_pix_d;
    logic signed [17:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    uq0_16              s1_inv_w_q, s1_inv_w_d, s1_inv_h_q, s1_inv_h_d;

    logic               s2_valid_q, s2_valid_d;
    vec2_i16            s2_pix_q, s2_pix_d;
    logic signed [34:0] s2_px_q, s2_px_d, s2_py_q, s2_py_d;

    logic               s3_valid_q, s3_valid_d;
    vec2_i16            s3_pix_q, s3_pix_d;
    logic signed [35:0] s3_qx_q, s3_qx_d, s3_qy_q, s3_qy_d;

    logic               ndc_valid_q, ndc_valid_d;
    vec2_f16            ndc_pt_q, ndc_pt_d;
    vec2_i16            ndc_pix_q, ndc_pix_d;

    logic signed [34:0] a_ext, b_ext, w_ext, h_ext;
    f16                 f16_x, f16_y;

    assign en        = !ndc_valid_q || ndc_ready;
    assign pix_ready = en;
    assign ndc_valid = ndc_valid_q;
    assign ndc_pt    = ndc_pt_q;
    assign ndc_pix   = ndc_pix_q;

    raster_to_ndc_fixed_to_f16 u_cvt_x (
        .val_i (s3_qx_q),
        .f16_o (f16_x)
    );

    raster_to_ndc_fixed_to_f16 u_cvt_y (
        .val_i (s3_qy_q),
        .f16_o (f16_y)
    );

    // Next state: config regs load independently of the stall; all stages shift together on en
    always_comb begin
        inv_w_d     = inv_w_q;
        inv_h_d     = inv_h_q;
        s1_valid_d  = s1_valid_q;
        s1_pix_d    = s1_pix_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_inv_w_d  = s1_inv_w_q;
        s1_inv_h_d  = s1_inv_h_q;
        s2_valid_d  = s2_valid_q;
        s2_pix_d    = s2_pix_q;
        s2_px_d     = s2_px_q;
        s2_py_d     = s2_py_q;
        s3_valid_d  = s3_valid_q;
        s3_pix_d    = s3_pix_q;
        s3_qx_d     = s3_qx_q;
        s3_qy_d     = s3_qy_q;
        ndc_valid_d = ndc_valid_q;
        ndc_pt_d    = ndc_pt_q;
        ndc_pix_d   = ndc_pix_q;

        // inv is a Q0.16 fraction: zero-extend before the signed multiply
        a_ext = 35'(s1_a_q);
        b_ext = 35'(s1_b_q);
        w_ext = 35'($signed({1'b0, s1_inv_w_q}));
        h_ext = 35'($signed({1'b0, s1_inv_h_q}));

        if (cfg_load) begin
            inv_w_d = cfg_inv_w;
            inv_h_d = cfg_inv_h;
        end

        if (en) begin
            // 2x+c with c in {0,1}: bit 0 of 2x is zero, so c just fills it
            s1_valid_d  = pix_valid;
            s1_pix_d    = pix;
            s1_a_d      = {pix.x[15], pix.x, CENTER};
            s1_b_d      = {pix.y[15], pix.y, CENTER};
            s1_inv_w_d  = inv_w_q;
            s1_inv_h_d  = inv_h_q;

            s2_valid_d  = s1_valid_q;
            s2_pix_d    = s1_pix_q;
            s2_px_d     = a_ext * w_ext;
            s2_py_d     = b_ext * h_ext;

            s3_valid_d  = s2_valid_q;
            s3_pix_d    = s2_pix_q;
            s3_qx_d     = 36'(s2_px_q);
            s3_qy_d     = OneQ - 36'(s2_py_q);

            ndc_valid_d = s3_valid_q;
            ndc_pt_d    = {f16_y, f16_x};
            ndc_pix_d   = s3_pix_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_w_q     <= '0;
            inv_h_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_inv_w_q  <= '0;
            s1_inv_h_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_pix_q    <= '0;
            s2_px_q     <= '0;
            s2_py_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_pix_q    <= '0;
            s3_qx_q     <= '0;
            s3_qy_q     <= '0;
            ndc_valid_q <= 1'b0;
            ndc_pt_q    <= '0;
            ndc_pix_q   <= '0;
        end else begin
            inv_w_q     <= inv_w_d;
            inv_h_q     <= inv_h_d;
            s1_valid_q  <= s1_valid_d;
            s1_pix_q    <= s1_pix_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_inv_w_q  <= s1_inv_w_d;
            s1_inv_h_q  <= s1_inv_h_d;
            s2_valid_q  <= s2_valid_d;
            s2_pix_q    <= s2_pix_d;
            s2_px_q     <= s2_px_d;
            s2_py_q     <= s2_py_d;
            s3_valid_q  <= s3_valid_d;
            s3_pix_q    <= s3_pix_d;
            s3_qx_q     <= s3_qx_d;
            s3_qy_q     <= s3_qy_d;
            ndc_valid_q <= ndc_valid_d;
            ndc_pt_q    <= ndc_pt_d;
            ndc_pix_q   <= ndc_pix_d;
        end
    end

endmodule
